// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states and the
// PC_Src / ALUSrcB / ALUOp codes used by PC_Gen, ALU control and the datapath.
package mc_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXE,
        S_R_WB,
        S_I_EXE,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_e;

    // Where DECODE sends each opcode; unknown opcodes either park or retry.
    function automatic state_e decodeDispatch(input logic [5:0] opcode, input logic illegalHalt);
        state_e nxt;
        case (opcode)
            OP_RTYPE:      nxt = S_R_EXE;
            OP_LW, OP_SW:  nxt = S_MEM_ADDR;
            OP_ADDI:       nxt = S_I_EXE;
            OP_BEQ, OP_BNE: nxt = S_BRANCH;
            OP_J:          nxt = S_JUMP;
            default:       nxt = illegalHalt ? S_HALT : S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_control.sv
// Moore-style control FSM for a multicycle MIPS-like datapath; only PC_Write
// looks at an input (ALU_ZERO) so branches can qualify the PC load directly.
module mc_control
    import mc_control_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       ALU_ZERO,
    output logic [1:0] PC_Src,
    output logic       PC_Write,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       Instr_Done,
    output logic       Halted
);

    state_e state_q, state_d;
    logic   initDone_q;
    logic   isBne_q, isBne_d;

    // initDone_q holds INIT for one extra clock so FETCH lands on the second edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            initDone_q <= 1'b0;
            isBne_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            initDone_q <= 1'b1;
            isBne_q    <= isBne_d;
        end
    end

    always_comb begin
        state_d = state_q;
        isBne_d = isBne_q;
        case (state_q)
            S_INIT:     if (initDone_q) state_d = S_FETCH;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                state_d = decodeDispatch(Opcode, ILLEGAL_HALT);
                isBne_d = (Opcode == OP_BNE);
            end
            S_MEM_ADDR: state_d = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_R_EXE:    state_d = S_R_WB;
            S_I_EXE:    state_d = S_I_WB;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP:
                        state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_INIT;
        endcase
    end

    always_comb begin
        PC_Src     = PCSRC_ALU;
        PC_Write   = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = ALUB_REG;
        ALUOp      = ALUOP_ADD;
        Instr_Done = 1'b0;
        Halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = ALUB_FOUR;
                PC_Write = 1'b1;
            end
            S_DECODE:   ALUSrcB = ALUB_IMM_SH;
            S_MEM_ADDR, S_I_EXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUB_IMM;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                Instr_Done = 1'b1;
            end
            S_MEM_WR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                Instr_Done = 1'b1;
            end
            S_R_EXE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                Instr_Done = 1'b1;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                Instr_Done = 1'b1;
            end
            // The beq/bne flavour was captured in DECODE since Opcode is not looked at here.
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_SUB;
                PC_Src     = PCSRC_TARGET;
                PC_Write   = ALU_ZERO ^ isBne_q;
                Instr_Done = 1'b1;
            end
            S_JUMP: begin
                PC_Src     = PCSRC_JUMP;
                PC_Write   = 1'b1;
                Instr_Done = 1'b1;
            end
            S_HALT:     Halted = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: ILLEGAL_HALT, default 0, meaning 1 = an illegal opcode parks the FSM in HALT until reset, 0 = it returns to FETCH.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 Opcode  input  6  IR[31:26] of the latched instruction.
REQ-006 ALU_ZERO  input  1  ALU zero flag in the branch-compare cycle.
REQ-007 PC_Src  output  2  next-PC select: 00 = alu_out (PC+4), 01 = alu_out_reg (branch target), 10 = jump target.
REQ-008 PC_Write  output  1  PC load enable, already qualified by the branch condition.
REQ-009 IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  standard multicycle datapath strobes/selects.
REQ-010 ALUSrcB  output  2  ALU B operand select: 00 = reg B, 01 = constant 4, 10 = sext imm, 11 = sext imm<<2.
REQ-011 ALUOp  output  2  ALU operation: 00 = add, 01 = sub, 10 = use funct field.
REQ-012 Instr_Done  output  1  one-cycle pulse in the final state of each instruction.
REQ-013 Halted  output  1  high while in HALT.

Function
REQ-014 The FSM SHALL be Moore: every output decodes from the state register only, except PC_Write.
REQ-015 States SHALL be INIT, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXE, R_WB, I_EXE, I_WB, BRANCH, JUMP, HALT.
REQ-016 INIT: all outputs 0; next state FETCH.
REQ-017 FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PC_Src=00, PC_Write=1; next state DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, so the branch target is latched in alu_out_reg.
REQ-019 DECODE dispatch: 000000→R_EXE; 100011/101011→MEM_ADDR; 001000→I_EXE; 000100/000101→BRANCH; 000010→JUMP; any other opcode→HALT if ILLEGAL_HALT=1, else FETCH.
REQ-020 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw→MEM_RD, sw→MEM_WR.
REQ-021 MEM_RD: IorD=1, MemRead=1; next MEM_WB.
REQ-022 MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, Instr_Done=1; next FETCH.
REQ-023 MEM_WR: IorD=1, MemWrite=1, Instr_Done=1; next FETCH.
REQ-024 R_EXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next R_WB.
REQ-025 R_WB: RegDst=1, MemtoReg=0, RegWrite=1, Instr_Done=1; next FETCH.
REQ-026 I_EXE: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next I_WB.
REQ-027 I_WB: RegDst=0, MemtoReg=0, RegWrite=1, Instr_Done=1; next FETCH.
REQ-028 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PC_Src=01, Instr_Done=1; next FETCH.
REQ-029 BRANCH PC_Write SHALL equal ALU_ZERO for beq and ~ALU_ZERO for bne; in every other state PC_Write is state-only.
REQ-030 JUMP: PC_Src=10, PC_Write=1, Instr_Done=1; next FETCH.
REQ-031 HALT: all strobes 0, Halted=1; remains in HALT until rst_n is low.
REQ-032 Opcode SHALL be sampled only in DECODE and MEM_ADDR; changes in other cycles have no effect.
REQ-033 Latency from FETCH entry to the next FETCH entry: R/addi/sw 4 cycles; lw 5; beq/bne/j 3.
REQ-034 MemRead, MemWrite and RegWrite SHALL never be asserted in the same cycle.

Reset
REQ-035 rst_n low SHALL force state INIT immediately and asynchronously, from any state including mid-instruction and HALT.
REQ-036 While in INIT, every output SHALL be 0, including PC_Write, Instr_Done and Halted.
REQ-037 The first FETCH SHALL occur on the second rising clk after rst_n deasserts.

Structure
REQ-038 The opcode constants, state encodings and the PC_Src/ALUSrcB/ALUOp codes SHALL live in a shared package/include used by PC_Gen, the ALU control and the datapath.
REQ-039 The block SHALL be one state-register process plus combinational next-state and output decode.
REQ-040 No sub-module is required.

Verification
REQ-041 lw (Opcode=100011): state sequence FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; RegWrite=1 and MemtoReg=1 only in cycle 5; Instr_Done pulses once.
REQ-042 beq with ALU_ZERO=1 → PC_Write=1, PC_Src=01 in cycle 3; with ALU_ZERO=0 → PC_Write=0; bne gives the inverse results.
REQ-043 j (000010) → PC_Src=10, PC_Write=1 in cycle 3, then FETCH.
REQ-044 Opcode=111111 with ILLEGAL_HALT=1 → HALT and Halted=1 held for 20 cycles; with ILLEGAL_HALT=0 → FETCH after DECODE.
REQ-045 rst_n pulsed low during MEM_RD → INIT with all outputs 0 in the same cycle, then FETCH 2 clocks after release.
REQ-046 Back-to-back R, sw, addi → 12 cycles total, 3 Instr_Done pulses, and no cycle with multiple write strobes.
